// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : midi_voice_allocator
// Description : Polyphonic voice scheduler. It maps framed MIDI note events
//               onto NUM_VOICES slots and steals the oldest slot when all
//               slots are busy.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int IDX_BITS      = 2,
  parameter int AGE_BITS      = 4,
  parameter int RETRIG_CYCLES = 400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    event_valid,
  input  logic [7:0]              event_command,
  input  logic [7:0]              event_param1,
  input  logic [7:0]              event_param2,
  output logic                    event_ack,
  output logic                    busy,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity
);

  localparam int                  c_CNT_BITS = $clog2(RETRIG_CYCLES + 1);
  localparam logic [IDX_BITS-1:0] c_LAST_IDX = IDX_BITS'(NUM_VOICES - 1);
  localparam logic [AGE_BITS-1:0] c_AGE_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_APPLY    = 3'd2,
    S_RETRIG   = 3'd3,
    S_ACK      = 3'd4,
    S_WAIT_LOW = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_OTHER   = 2'd0,
    K_ON      = 2'd1,
    K_OFF     = 2'd2,
    K_ALL_OFF = 2'd3
  } kind_t;

  state_t r_state, w_state_next;
  kind_t  w_kind, r_kind;

  logic [6:0]            r_p_note, r_p_vel;
  logic [IDX_BITS-1:0]   r_scan_idx;
  logic                  r_match_found, r_free_found;
  logic [IDX_BITS-1:0]   r_match_idx, r_free_idx, r_old_idx;
  logic [AGE_BITS-1:0]   r_old_age;
  logic [c_CNT_BITS-1:0] r_cnt;
  logic                  r_ack, r_busy;

  logic [NUM_VOICES-1:0] r_gate;
  logic [6:0]            r_note [NUM_VOICES];
  logic [6:0]            r_vel  [NUM_VOICES];
  logic [AGE_BITS-1:0]   r_age  [NUM_VOICES];

  logic [IDX_BITS-1:0]   w_target;
  logic                  w_retrig;
  logic                  w_unused;

  // Channel nibble and the data-byte MSBs carry no meaning here.
  assign w_unused = ^{event_command[3:0], event_param1[7], event_param2[7]};

  always_comb begin
    w_kind = K_OTHER;
    if (event_command[7:4] == 4'h9 && event_param2[6:0] != 7'd0)
      w_kind = K_ON;
    else if (event_command[7:4] == 4'h8 || event_command[7:4] == 4'h9)
      w_kind = K_OFF;
    else if (event_command[7:4] == 4'hB && event_param1[6:0] == 7'd123)
      w_kind = K_ALL_OFF;
  end

  // Re-striking a sounding note or stealing both need a gate-low gap.
  always_comb begin
    w_retrig = r_match_found || !r_free_found;
    if (r_match_found)
      w_target = r_match_idx;
    else if (r_free_found)
      w_target = r_free_idx;
    else
      w_target = r_old_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:     if (event_valid) w_state_next = S_SCAN;
      S_SCAN:     if (r_scan_idx == c_LAST_IDX) w_state_next = S_APPLY;
      S_APPLY:    w_state_next = (r_kind == K_ON && w_retrig) ? S_RETRIG : S_ACK;
      S_RETRIG:   if (r_cnt == c_CNT_BITS'(1)) w_state_next = S_ACK;
      S_ACK:      w_state_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!event_valid) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack         <= 1'b0;
      r_busy        <= 1'b0;
      r_kind        <= K_OTHER;
      r_p_note      <= '0;
      r_p_vel       <= '0;
      r_scan_idx    <= '0;
      r_match_found <= 1'b0;
      r_free_found  <= 1'b0;
      r_match_idx   <= '0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      r_cnt         <= '0;
      r_gate        <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v] <= '0;
        r_vel[v]  <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_ack  <= (w_state_next == S_ACK);
      r_busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (event_valid) begin
            r_kind        <= w_kind;
            r_p_note      <= event_param1[6:0];
            r_p_vel       <= event_param2[6:0];
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!r_match_found && r_gate[r_scan_idx] && r_note[r_scan_idx] == r_p_note) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_scan_idx;
          end
          if (!r_free_found && !r_gate[r_scan_idx]) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_scan_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (r_scan_idx == '0 || r_age[r_scan_idx] > r_old_age) begin
            r_old_idx <= r_scan_idx;
            r_old_age <= r_age[r_scan_idx];
          end
          r_scan_idx <= r_scan_idx + 1'b1;
        end
        S_APPLY: begin
          case (r_kind)
            K_ON: begin
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (IDX_BITS'(v) == w_target) begin
                  r_note[v] <= r_p_note;
                  r_vel[v]  <= r_p_vel;
                  r_age[v]  <= '0;
                  r_gate[v] <= !w_retrig;
                end else if (r_gate[v] && r_age[v] != c_AGE_MAX) begin
                  r_age[v] <= r_age[v] + 1'b1;
                end
              end
              if (w_retrig)
                r_cnt <= c_CNT_BITS'(RETRIG_CYCLES);
            end
            K_OFF: begin
              // Note and velocity stay put so the release tail keeps its pitch.
              for (int v = 0; v < NUM_VOICES; v++)
                if (r_gate[v] && r_note[v] == r_p_note)
                  r_gate[v] <= 1'b0;
            end
            K_ALL_OFF: begin
              r_gate <= '0;
              for (int v = 0; v < NUM_VOICES; v++)
                r_age[v] <= '0;
            end
            default: ;
          endcase
        end
        S_RETRIG: begin
          if (r_cnt == c_CNT_BITS'(1))
            r_gate[w_target] <= 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign event_ack  = r_ack;
  assign busy       = r_busy;
  assign voice_gate = r_gate;

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
      assign voice_note[7*v +: 7]     = r_note[v];
      assign voice_velocity[7*v +: 7] = r_vel[v];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_voice_allocator
// Description : Directed bench for midi_voice_allocator with a cycle-level
//               voice model and hand-computed pin checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_voice_allocator;

  localparam int NV      = 4;
  localparam int RC      = 8;
  localparam int AGE_MAX = 15;
  localparam int VW      = 2 + NV + 14*NV;

  logic             clk = 1'b0;
  logic             rst;
  logic             event_valid;
  logic [7:0]       event_command, event_param1, event_param2;
  logic             event_ack, busy;
  logic [NV-1:0]    voice_gate;
  logic [7*NV-1:0]  voice_note, voice_velocity;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  int m_gate[NV], m_note[NV], m_vel[NV], m_age[NV];
  int n_gate[NV], n_note[NV], n_vel[NV], n_age[NV];
  bit m_ack  = 1'b0;
  bit m_busy = 1'b0;

  logic [VW-1:0] cmp_act, cmp_exp;

  always #5 clk = ~clk;

  midi_voice_allocator #(
    .NUM_VOICES    (NV),
    .IDX_BITS      (2),
    .AGE_BITS      (4),
    .RETRIG_CYCLES (RC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .event_valid    (event_valid),
    .event_command  (event_command),
    .event_param1   (event_param1),
    .event_param2   (event_param2),
    .event_ack      (event_ack),
    .busy           (busy),
    .voice_gate     (voice_gate),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity)
  );

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole output vector checked against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_exp = '0;
      for (int v = 0; v < NV; v++) begin
        cmp_exp[14*NV + v]      = (m_gate[v] != 0);
        cmp_exp[7*NV + 7*v +: 7] = 7'(m_note[v]);
        cmp_exp[7*v +: 7]        = 7'(m_vel[v]);
      end
      cmp_exp[15*NV]     = m_ack;
      cmp_exp[15*NV + 1] = m_busy;
      cmp_act = {busy, event_ack, voice_gate, voice_note, voice_velocity};
      vectors++;
      if (cmp_act !== cmp_exp) begin
        miscompares++;
        $display("FAIL cycle_vec @%0t: got %h expected %h", $time, cmp_act, cmp_exp);
      end
    end
  end

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_age[v] = 0;
    end
    m_ack  = 1'b0;
    m_busy = 1'b0;
  endtask

  // Computes the post-event voice state from the allocation rules.
  task automatic model_event(input logic [7:0] c, input logic [7:0] p1, input logic [7:0] p2,
                             output bit rt, output int tg);
    int key, vel, match, free, old;
    n_gate = m_gate; n_note = m_note; n_vel = m_vel; n_age = m_age;
    rt  = 1'b0;
    tg  = 0;
    key = int'(p1[6:0]);
    vel = int'(p2[6:0]);
    if (c[7:4] == 4'h9 && vel != 0) begin
      match = -1; free = -1; old = 0;
      for (int v = 0; v < NV; v++) begin
        if (match < 0 && m_gate[v] != 0 && m_note[v] == key) match = v;
        if (free < 0 && m_gate[v] == 0) free = v;
        if (m_age[v] > m_age[old]) old = v;
      end
      tg = (match >= 0) ? match : (free >= 0) ? free : old;
      rt = (match >= 0) || (free < 0);
      for (int v = 0; v < NV; v++) begin
        if (v == tg) begin
          n_note[v] = key; n_vel[v] = vel; n_age[v] = 0; n_gate[v] = rt ? 0 : 1;
        end else if (m_gate[v] != 0 && m_age[v] < AGE_MAX) begin
          n_age[v] = m_age[v] + 1;
        end
      end
    end else if (c[7:4] == 4'h8 || c[7:4] == 4'h9) begin
      for (int v = 0; v < NV; v++)
        if (m_gate[v] != 0 && m_note[v] == key) n_gate[v] = 0;
    end else if (c[7:4] == 4'hB && key == 123) begin
      for (int v = 0; v < NV; v++) begin
        n_gate[v] = 0; n_age[v] = 0;
      end
    end
  endtask

  // Presents one event, advances the model on the expected edges, and
  // reports the cycle (relative to acceptance edge E) where ack appeared.
  task automatic send(input logic [7:0] c, input logic [7:0] p1, input logic [7:0] p2,
                      input int hold, input int abort_k, output int ack_at);
    bit rt;
    int tg, lat, guard;
    ack_at = -1;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    lit("idle_wait", int'(busy), 0);
    model_event(c, p1, p2, rt, tg);
    lat = NV + 2 + (rt ? RC : 0);
    event_command = c;
    event_param1  = p1;
    event_param2  = p2;
    event_valid   = 1'b1;
    @(posedge clk);
    m_busy = 1'b1;
    for (int k = 1; k <= lat + hold; k++) begin
      @(posedge clk);
      if (k == NV + 1) begin
        m_gate = n_gate; m_note = n_note; m_vel = n_vel; m_age = n_age;
      end
      if (k == lat - 1) begin
        m_ack = 1'b1;
        if (rt) m_gate[tg] = 1;
      end
      if (k == lat) m_ack = 1'b0;
      #1;
      if (event_ack && ack_at < 0) ack_at = k + 1;
      if (k == 1) begin
        event_param1 = p1 ^ 8'h55;
        event_param2 = p2 ^ 8'h2A;
      end
      if (k == abort_k) begin
        #1;
        rst         = 1'b1;
        event_valid = 1'b0;
        model_reset();
        @(negedge clk);
        lit("abort_gate_now", int'(voice_gate), 0);
        lit("abort_busy_now", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    event_valid = 1'b0;
    @(posedge clk);
    m_busy = 1'b0;
  endtask

  initial begin
    int a;
    rst           = 1'b1;
    event_valid   = 1'b0;
    event_command = '0;
    event_param1  = '0;
    event_param2  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("rst_gate", int'(voice_gate), 0);
    lit("rst_busy", int'(busy), 0);
    lit("rst_ack", int'(event_ack), 0);
    lit("rst_note", int'(voice_note), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset in the middle of a retrigger.
    send(8'h90, 8'd60, 8'd100, 0, 0, a);
    send(8'h90, 8'd60, 8'd100, 0, 8, a);
    lit("abort_gate", int'(voice_gate), 0);

    // Single note-on, valid held a few cycles past the ack.
    send(8'h90, 8'd60, 8'd100, 3, 0, a);
    lit("on_lat", a, 6);
    lit("on_gate", int'(voice_gate), 1);
    lit("on_note0", int'(voice_note[6:0]), 60);
    lit("on_vel0", int'(voice_velocity[6:0]), 100);

    // Fill all voices, then steal the oldest.
    send(8'h90, 8'd62, 8'd80, 0, 0, a);
    send(8'h90, 8'd64, 8'd80, 0, 0, a);
    send(8'h90, 8'd65, 8'd80, 0, 0, a);
    send(8'h90, 8'd67, 8'd110, 0, 0, a);
    lit("steal_lat", a, 14);
    lit("steal_note0", int'(voice_note[6:0]), 67);
    lit("steal_gate", int'(voice_gate), 15);

    // Re-strike of a sounding note.
    send(8'h90, 8'd62, 8'd90, 0, 0, a);
    lit("retrig_lat", a, 14);
    lit("retrig_note1", int'(voice_note[13:7]), 62);
    lit("retrig_vel1", int'(voice_velocity[13:7]), 90);

    // Note-offs.
    send(8'h80, 8'd62, 8'd0, 0, 0, a);
    lit("off_gate", int'(voice_gate), 13);
    lit("off_note1", int'(voice_note[13:7]), 62);
    send(8'h90, 8'd64, 8'd0, 0, 0, a);
    lit("off_v0_gate", int'(voice_gate), 9);
    send(8'h80, 8'd99, 8'd0, 0, 0, a);
    lit("off_none_lat", a, 6);
    lit("off_none_gate", int'(voice_gate), 9);
    send(8'h91, 8'd72, 8'd50, 0, 0, a);
    lit("free_gate", int'(voice_gate), 11);
    lit("free_note1", int'(voice_note[13:7]), 72);

    // Command coverage.
    send(8'hB3, 8'd123, 8'd0, 0, 0, a);
    lit("alloff_gate", int'(voice_gate), 0);
    lit("alloff_lat", a, 6);
    send(8'hE0, 8'h10, 8'h40, 5, 0, a);
    lit("bend_lat", a, 6);
    send(8'hB0, 8'd7, 8'd100, 0, 0, a);
    lit("cc_gate", int'(voice_gate), 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
